// File: rtl/parser_rule_cfg_ctrl.sv
// Configuration sequencer: serialises host register reads/writes onto the rule
// ports of LAYER_NUM parser layers, with read timeout and a single response per request.
module parser_rule_cfg_ctrl #(
   parameter int LAYER_NUM = 4,
   parameter int TIMEOUT   = 16
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_req_valid,
   output logic                    o_req_ready,
   input  logic                    i_req_we,
   input  logic [31:0]             i_req_addr,
   input  logic [31:0]             i_req_wdata,
   output logic                    o_resp_valid,
   input  logic                    i_resp_ready,
   output logic [31:0]             o_resp_rdata,
   output logic                    o_resp_err,
   output logic [LAYER_NUM-1:0]    o_rule_wren,
   output logic [LAYER_NUM-1:0]    o_rule_rden,
   output logic [31:0]             o_rule_addr,
   output logic [31:0]             o_rule_wdata,
   input  logic [LAYER_NUM-1:0]    i_rule_rdata_valid,
   input  logic [LAYER_NUM*32-1:0] i_rule_rdata,
   output logic [15:0]             o_err_cnt
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

   localparam int               CNT_W        = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(TIMEOUT - 2);
   localparam logic [3:0]       LAYER_NUM_ID = 4'(LAYER_NUM);
   localparam logic [3:0]       BCAST_ID     = 4'hF;

   state_t                 state_q, state_d;
   logic                   we_q, we_d;
   logic [3:0]             id_q, id_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   req_ready_d, resp_valid_d, resp_err_d;
   logic [31:0]            resp_rdata_d, rule_addr_d, rule_wdata_d;
   logic [LAYER_NUM-1:0]   rule_wren_d, rule_rden_d;
   logic [15:0]            err_cnt_d;

   logic [3:0]             req_id;
   logic                   req_bcast, req_bad;
   logic [LAYER_NUM-1:0]   req_mask;
   logic                   sel_valid;
   logic [31:0]            sel_rdata;

   // Request decode, and read-data select restricted to the registered target layer.
   // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      req_id    = i_req_addr[31:28];
      req_bcast = (req_id == BCAST_ID);
      req_bad   = req_bcast ? !i_req_we : (req_id >= LAYER_NUM_ID);
      req_mask  = '0;
      sel_valid = 1'b0;
      sel_rdata = '0;
      for (int k = 0; k < LAYER_NUM; k++) begin
         req_mask[k] = req_bcast || (req_id == 4'(k));
         if (id_q == 4'(k)) begin
            sel_valid = i_rule_rdata_valid[k];
            sel_rdata = i_rule_rdata[k*32 +: 32];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      id_d         = id_q;
      cnt_d        = cnt_q;
      resp_valid_d = o_resp_valid;
      resp_rdata_d = o_resp_rdata;
      resp_err_d   = o_resp_err;
      rule_addr_d  = o_rule_addr;
      rule_wdata_d = o_rule_wdata;
      rule_wren_d  = '0;
      rule_rden_d  = '0;
      err_cnt_d    = o_err_cnt;

      case (state_q)
         IDLE: begin
            if (i_req_valid && o_req_ready) begin
               we_d = i_req_we;
               id_d = req_id;
               if (req_bad) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = '0;
               end else begin
                  state_d      = ISSUE;
                  rule_addr_d  = {4'b0, i_req_addr[27:0]};
                  rule_wdata_d = i_req_wdata;
                  if (i_req_we) rule_wren_d = req_mask;
                  else          rule_rden_d = req_mask;
               end
            end
         end
         ISSUE: begin
            if (we_q || sel_valid) begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b0;
               resp_rdata_d = we_q ? 32'h0 : sel_rdata;
            end else begin
               state_d = WAIT_RD;
               cnt_d   = '0;
            end
         end
         WAIT_RD: begin
            // Valid in the expiry cycle takes priority over the timeout.
            if (sel_valid) begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b0;
               resp_rdata_d = sel_rdata;
            end else if (cnt_q == CNT_LAST) begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b1;
               resp_rdata_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: begin
            if (i_resp_ready) begin
               state_d      = IDLE;
               resp_valid_d = 1'b0;
               resp_err_d   = 1'b0;
               resp_rdata_d = '0;
               if (o_resp_err && (o_err_cnt != 16'hFFFF)) err_cnt_d = o_err_cnt + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      req_ready_d = (state_d == IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= IDLE;
         we_q         <= 1'b0;
         id_q         <= '0;
         cnt_q        <= '0;
         o_req_ready  <= 1'b1;
         o_resp_valid <= 1'b0;
         o_resp_rdata <= '0;
         o_resp_err   <= 1'b0;
         o_rule_wren  <= '0;
         o_rule_rden  <= '0;
         o_rule_addr  <= '0;
         o_rule_wdata <= '0;
         o_err_cnt    <= '0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         id_q         <= id_d;
         cnt_q        <= cnt_d;
         o_req_ready  <= req_ready_d;
         o_resp_valid <= resp_valid_d;
         o_resp_rdata <= resp_rdata_d;
         o_resp_err   <= resp_err_d;
         o_rule_wren  <= rule_wren_d;
         o_rule_rden  <= rule_rden_d;
         o_rule_addr  <= rule_addr_d;
         o_rule_wdata <= rule_wdata_d;
         o_err_cnt    <= err_cnt_d;
      end
   end

endmodule

// File: tb/tb_parser_rule_cfg_ctrl.sv
// Directed bench for parser_rule_cfg_ctrl: writes, reads, timeout, bad IDs,
// broadcast, back-pressure and mid-transaction reset.
module tb_parser_rule_cfg_ctrl;

   localparam int LAYER_NUM = 4;
   localparam int TIMEOUT   = 16;

   logic                    i_clk = 1'b0;
   logic                    i_rst_n;
   logic                    i_req_valid;
   logic                    o_req_ready;
   logic                    i_req_we;
   logic [31:0]             i_req_addr;
   logic [31:0]             i_req_wdata;
   logic                    o_resp_valid;
   logic                    i_resp_ready;
   logic [31:0]             o_resp_rdata;
   logic                    o_resp_err;
   logic [LAYER_NUM-1:0]    o_rule_wren;
   logic [LAYER_NUM-1:0]    o_rule_rden;
   logic [31:0]             o_rule_addr;
   logic [31:0]             o_rule_wdata;
   logic [LAYER_NUM-1:0]    i_rule_rdata_valid;
   logic [LAYER_NUM*32-1:0] i_rule_rdata;
   logic [15:0]             o_err_cnt;

   int n_vec = 0;
   int n_err = 0;

   parser_rule_cfg_ctrl #(.LAYER_NUM(LAYER_NUM), .TIMEOUT(TIMEOUT)) dut (
      .i_clk              (i_clk),
      .i_rst_n            (i_rst_n),
      .i_req_valid        (i_req_valid),
      .o_req_ready        (o_req_ready),
      .i_req_we           (i_req_we),
      .i_req_addr         (i_req_addr),
      .i_req_wdata        (i_req_wdata),
      .o_resp_valid       (o_resp_valid),
      .i_resp_ready       (i_resp_ready),
      .o_resp_rdata       (o_resp_rdata),
      .o_resp_err         (o_resp_err),
      .o_rule_wren        (o_rule_wren),
      .o_rule_rden        (o_rule_rden),
      .o_rule_addr        (o_rule_addr),
      .o_rule_wdata       (o_rule_wdata),
      .i_rule_rdata_valid (i_rule_rdata_valid),
      .i_rule_rdata       (i_rule_rdata),
      .o_err_cnt          (o_err_cnt)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic request(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      i_req_valid = 1'b1;
      i_req_we    = we;
      i_req_addr  = addr;
      i_req_wdata = wdata;
      step();
      i_req_valid = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_resp_valid"}, 32'(o_resp_valid), 32'h0);
      check({tag, "_req_ready"},  32'(o_req_ready),  32'h1);
      check({tag, "_rden"},       32'(o_rule_rden),  32'h0);
      check({tag, "_wren"},       32'(o_rule_wren),  32'h0);
   endtask

   initial begin
      i_rst_n            = 1'b0;
      i_req_valid        = 1'b0;
      i_req_we           = 1'b0;
      i_req_addr         = '0;
      i_req_wdata        = '0;
      i_resp_ready       = 1'b1;
      i_rule_rdata_valid = '0;
      i_rule_rdata       = '0;
      #12;
      check_idle_outputs("reset");
      check("reset_rdata",   o_resp_rdata,     32'h0);
      check("reset_err",     32'(o_resp_err),  32'h0);
      check("reset_addr",    o_rule_addr,      32'h0);
      check("reset_wdata",   o_rule_wdata,     32'h0);
      check("reset_err_cnt", 32'(o_err_cnt),   32'h0);
      i_rst_n = 1'b1;
      step();

      // Write to layer 2.
      request(1'b1, 32'h2000_0010, 32'hA5A5_0001);
      check("wr_wren",       32'(o_rule_wren),  32'h4);
      check("wr_rden",       32'(o_rule_rden),  32'h0);
      check("wr_addr",       o_rule_addr,       32'h0000_0010);
      check("wr_wdata",      o_rule_wdata,      32'hA5A5_0001);
      check("wr_req_ready",  32'(o_req_ready),  32'h0);
      check("wr_early_resp", 32'(o_resp_valid), 32'h0);
      step();
      check("wr_resp_valid", 32'(o_resp_valid), 32'h1);
      check("wr_resp_err",   32'(o_resp_err),   32'h0);
      check("wr_resp_rdata", o_resp_rdata,      32'h0);
      check("wr_wren_pulse", 32'(o_rule_wren),  32'h0);
      step();
      check_idle_outputs("wr_done");

      // Read layer 1 with data in the rden cycle.
      request(1'b0, 32'h1000_0020, 32'h0);
      check("rd1_rden", 32'(o_rule_rden), 32'h2);
      check("rd1_addr", o_rule_addr,      32'h0000_0020);
      i_rule_rdata_valid       = 4'b0010;
      i_rule_rdata[1*32 +: 32] = 32'h1234_5678;
      step();
      i_rule_rdata_valid = '0;
      check("rd1_resp_valid", 32'(o_resp_valid), 32'h1);
      check("rd1_resp_rdata", o_resp_rdata,      32'h1234_5678);
      check("rd1_resp_err",   32'(o_resp_err),   32'h0);
      check("rd1_rden_pulse", 32'(o_rule_rden),  32'h0);
      step();
      check_idle_outputs("rd1_done");

      // Read layer 3, data 5 cycles after rden; other layers pulse valid meanwhile.
      request(1'b0, 32'h3000_0030, 32'h0);
      check("rd3_rden", 32'(o_rule_rden), 32'h8);
      i_rule_rdata[0*32 +: 32] = 32'hDEAD_0000;
      i_rule_rdata[1*32 +: 32] = 32'hDEAD_0001;
      i_rule_rdata[2*32 +: 32] = 32'hDEAD_0002;
      i_rule_rdata_valid       = 4'b0111;
      for (int i = 1; i <= 4; i++) begin
         step();
         check("rd3_wait_resp", 32'(o_resp_valid), 32'h0);
         check("rd3_wait_addr", o_rule_addr,       32'h0000_0030);
      end
      step();
      i_rule_rdata_valid       = 4'b1111;
      i_rule_rdata[3*32 +: 32] = 32'hCAFE_0003;
      step();
      i_rule_rdata_valid = '0;
      check("rd3_resp_valid", 32'(o_resp_valid), 32'h1);
      check("rd3_resp_rdata", o_resp_rdata,      32'hCAFE_0003);
      check("rd3_resp_err",   32'(o_resp_err),   32'h0);
      step();
      check_idle_outputs("rd3_done");

      // Read layer 0, never answers: error 16 cycles after the rden cycle.
      request(1'b0, 32'h0000_0040, 32'h0);
      check("to_rden", 32'(o_rule_rden), 32'h1);
      for (int i = 1; i < TIMEOUT; i++) begin
         step();
         check("to_wait_resp", 32'(o_resp_valid), 32'h0);
      end
      step();
      check("to_resp_valid", 32'(o_resp_valid), 32'h1);
      check("to_resp_err",   32'(o_resp_err),   32'h1);
      check("to_resp_rdata", o_resp_rdata,      32'h0);
      check("to_cnt_before", 32'(o_err_cnt),    32'h0);
      step();
      check("to_cnt_after",  32'(o_err_cnt),    32'h1);
      check_idle_outputs("to_done");

      // Bad layer ID 5.
      request(1'b0, 32'h5000_0000, 32'h0);
      check("bad_resp_valid", 32'(o_resp_valid), 32'h1);
      check("bad_resp_err",   32'(o_resp_err),   32'h1);
      check("bad_rden",       32'(o_rule_rden),  32'h0);
      check("bad_wren",       32'(o_rule_wren),  32'h0);
      step();
      check("bad_cnt", 32'(o_err_cnt), 32'h2);

      // Broadcast read is an error.
      request(1'b0, 32'hF000_0000, 32'h0);
      check("bcr_resp_valid", 32'(o_resp_valid), 32'h1);
      check("bcr_resp_err",   32'(o_resp_err),   32'h1);
      check("bcr_rden",       32'(o_rule_rden),  32'h0);
      check("bcr_wren",       32'(o_rule_wren),  32'h0);
      step();
      check("bcr_cnt", 32'(o_err_cnt), 32'h3);

      // Broadcast write strobes every layer.
      request(1'b1, 32'hF000_0004, 32'h0BAD_F00D);
      check("bcw_wren",  32'(o_rule_wren), 32'hF);
      check("bcw_addr",  o_rule_addr,      32'h0000_0004);
      check("bcw_wdata", o_rule_wdata,     32'h0BAD_F00D);
      step();
      check("bcw_wren_pulse", 32'(o_rule_wren),  32'h0);
      check("bcw_resp_valid", 32'(o_resp_valid), 32'h1);
      check("bcw_resp_err",   32'(o_resp_err),   32'h0);
      step();
      check_idle_outputs("bcw_done");

      // Back-pressure: response held, second request refused.
      i_resp_ready = 1'b0;
      request(1'b0, 32'h2000_0008, 32'h0);
      check("bp_rden", 32'(o_rule_rden), 32'h4);
      i_rule_rdata_valid       = 4'b0100;
      i_rule_rdata[2*32 +: 32] = 32'h55AA_33CC;
      step();
      i_rule_rdata_valid = '0;
      i_req_valid        = 1'b1;
      i_req_we           = 1'b1;
      i_req_addr         = 32'h0000_0000;
      i_req_wdata        = 32'h1111_2222;
      for (int i = 0; i < 10; i++) begin
         check("bp_resp_valid", 32'(o_resp_valid), 32'h1);
         check("bp_resp_rdata", o_resp_rdata,      32'h55AA_33CC);
         check("bp_resp_err",   32'(o_resp_err),   32'h0);
         check("bp_req_ready",  32'(o_req_ready),  32'h0);
         check("bp_wren",       32'(o_rule_wren),  32'h0);
         step();
      end
      i_req_valid  = 1'b0;
      i_resp_ready = 1'b1;
      step();
      check_idle_outputs("bp_done");
      check("bp_cnt", 32'(o_err_cnt), 32'h3);
      step();
      check("bp_no_late_wren", 32'(o_rule_wren), 32'h0);

      // Reset during WAIT_RD aborts the read.
      request(1'b0, 32'h1000_0050, 32'h0);
      check("rst_rden", 32'(o_rule_rden), 32'h2);
      step();
      step();
      #2;
      i_rst_n = 1'b0;
      #1;
      check_idle_outputs("rst_async");
      check("rst_addr",    o_rule_addr,     32'h0);
      check("rst_err_cnt", 32'(o_err_cnt),  32'h0);
      #1;
      i_rst_n = 1'b1;
      for (int i = 0; i < TIMEOUT + 4; i++) begin
         step();
         check("rst_no_resp", 32'(o_resp_valid), 32'h0);
         check("rst_no_rden", 32'(o_rule_rden),  32'h0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
